// File: rtl/addsel_pkg.sv
// ---------------------------------------------------------------------------
// addsel_pkg
// Shared definitions for the add-select pipeline.
//   sel_w(npair) : width of the pair-select index, never narrower than 1 bit
//   MODE_WRAP    : result wraps modulo 2**WIDTH on carry out
//   MODE_SAT     : result clamps to all-ones on carry out
// ---------------------------------------------------------------------------
package addsel_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // A single pair would give $clog2 == 0. Keep at least one select bit so
  // the port always exists.
  function automatic int sel_w(input int npair);
    int w;
    w = $clog2(npair);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/addsel_stage.sv
// ---------------------------------------------------------------------------
// addsel_stage
// One valid/ready register slice. It loads a new beat when it is empty or
// when its current beat leaves this cycle. Both stages of the add-select
// pipeline are instances of this slice.
// Ports:
//   Clk, Reset           clock (rising edge), async active-low reset
//   in_valid, in_data    upstream beat
//   in_ready             slice can take a beat this cycle (combinational)
//   out_valid, out_data  registered beat held by the slice
//   out_ready            downstream takes the held beat this cycle
// ---------------------------------------------------------------------------
module addsel_stage #(
  parameter int DW = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  logic          v_q, v_d;
  logic [DW-1:0] data_q, data_d;
  logic          take;

  // Data only changes when a real beat is loaded. A bubble passing through
  // leaves the old data in place, so the outputs stay steady while invalid.
  always_comb begin
    take   = !v_q || out_ready;
    v_d    = v_q;
    data_d = data_q;
    if (take) begin
      v_d = in_valid;
      if (in_valid) begin
        data_d = in_data;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

  assign in_ready  = take;
  assign out_valid = v_q;
  assign out_data  = data_q;

endmodule

// File: rtl/addsel_pipe.sv
// ---------------------------------------------------------------------------
// addsel_pipe
// Registered add-select datapath. One of NPAIR operand pairs is picked by
// sel and captured in stage 1. Stage 2 holds the sum, which either wraps or
// saturates. Both stages use valid/ready flow control with backpressure.
// A saturating tally counts delivered results that carried out.
// Ports:
//   Clk, Reset           clock (rising edge), async active-low reset
//   in_valid / in_ready  input handshake; in_ready is the only comb output
//   sel                  pair index; out-of-range values fall back to pair 0
//   din                  packed pairs, pair k = {B_k, A_k} at [2k*WIDTH +: 2*WIDTH]
//   out_valid/out_ready  output handshake
//   dout                 selected sum (wrapped or saturated)
//   dout_ovf             raw carry out of A+B for this result
//   sel_err              sel was out of range for this result
//   ovf_cnt              delivered results with dout_ovf=1, sticks at all-ones
//   clr_cnt              synchronous clear of ovf_cnt, beats an increment
// ---------------------------------------------------------------------------
module addsel_pipe
  import addsel_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NPAIR = 2,
  parameter  int SAT   = MODE_WRAP,
  parameter  int CNTW  = 16,
  localparam int SELW  = sel_w(NPAIR)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SELW-1:0]          sel,
  input  logic [2*NPAIR*WIDTH-1:0] din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         dout,
  output logic                     dout_ovf,
  output logic                     sel_err,
  output logic [CNTW-1:0]          ovf_cnt,
  input  logic                     clr_cnt
);

  // Stage 1 beat: {sel_err, A, B}.
  localparam int S1W = 2*WIDTH + 1;
  // Stage 2 beat: {sel_err, carry, result}.
  localparam int S2W = WIDTH + 2;

  logic [WIDTH-1:0] a_mux, b_mux;
  logic             err_mux;
  logic [S1W-1:0]   s1_in, s1_data;
  logic             s1_valid, s1_to_s2_ready;
  logic             s1_err;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [WIDTH:0]   sum_full;
  logic [WIDTH-1:0] sum_res;
  logic [S2W-1:0]   s2_in, s2_data;
  logic             s2_valid;
  logic [CNTW-1:0]  ovf_cnt_q, ovf_cnt_d;

  // The mux sits in front of stage 1, so only the chosen pair is
  // registered. Pair 0 is the default. It is also what an out-of-range
  // index uses, with the error flag set.
  always_comb begin
    a_mux   = din[0 +: WIDTH];
    b_mux   = din[WIDTH +: WIDTH];
    err_mux = 1'b1;
    for (int k = 0; k < NPAIR; k++) begin
      if (sel == SELW'(k)) begin
        a_mux   = din[(2*k)*WIDTH +: WIDTH];
        b_mux   = din[(2*k+1)*WIDTH +: WIDTH];
        err_mux = 1'b0;
      end
    end
  end

  assign s1_in = {err_mux, a_mux, b_mux};

  addsel_stage #(
    .DW (S1W)
  ) u_s1 (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (in_valid),
    .in_data   (s1_in),
    .in_ready  (in_ready),
    .out_valid (s1_valid),
    .out_data  (s1_data),
    .out_ready (s1_to_s2_ready)
  );

  assign s1_err = s1_data[2*WIDTH];
  assign s1_a   = s1_data[WIDTH +: WIDTH];
  assign s1_b   = s1_data[0 +: WIDTH];

  // Add with one extra bit. The carry is reported raw, even when the
  // result is clamped.
  always_comb begin
    sum_full = {1'b0, s1_a} + {1'b0, s1_b};
    sum_res  = sum_full[WIDTH-1:0];
    if ((SAT == MODE_SAT) && sum_full[WIDTH]) begin
      sum_res = '1;
    end
  end

  assign s2_in = {s1_err, sum_full[WIDTH], sum_res};

  addsel_stage #(
    .DW (S2W)
  ) u_s2 (
    .Clk       (Clk),
    .Reset     (Reset),
    .in_valid  (s1_valid),
    .in_data   (s2_in),
    .in_ready  (s1_to_s2_ready),
    .out_valid (s2_valid),
    .out_data  (s2_data),
    .out_ready (out_ready)
  );

  assign out_valid = s2_valid;
  assign sel_err   = s2_data[WIDTH+1];
  assign dout_ovf  = s2_data[WIDTH];
  assign dout      = s2_data[WIDTH-1:0];

  // Count only results that are actually handed downstream. Clear takes
  // priority, and the tally stops at all-ones instead of wrapping.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (clr_cnt) begin
      ovf_cnt_d = '0;
    end else if (s2_valid && out_ready && dout_ovf && (ovf_cnt_q != '1)) begin
      ovf_cnt_d = ovf_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_addsel_pipe.sv
// ---------------------------------------------------------------------------
// tb_addsel_pipe
// Drives two instances from the same stimulus. Both have three pairs. One
// wraps with a 2-bit tally and the other saturates with a 4-bit tally.
// A reference model tracks in-flight beats as a queue of expected results,
// each tagged with the cycle it was accepted, and checks every cycle.
// ---------------------------------------------------------------------------
module tb_addsel_pipe;

  localparam int W    = 8;
  localparam int NP   = 3;
  localparam int SELW = 2;
  localparam int CWA  = 2;
  localparam int CWB  = 4;

  logic              Clk;
  logic              Reset;
  logic              in_valid;
  logic              out_ready;
  logic              clr_cnt;
  logic [SELW-1:0]   sel;
  logic [2*NP*W-1:0] din;

  logic           in_ready_w, out_valid_w, ovf_w, err_w;
  logic [W-1:0]   dout_w;
  logic [CWA-1:0] cnt_w;
  logic           in_ready_s, out_valid_s, ovf_s, err_s;
  logic [W-1:0]   dout_s;
  logic [CWB-1:0] cnt_s;

  typedef struct {
    logic [W-1:0] wrap_sum;
    logic [W-1:0] sat_sum;
    logic         ovf;
    logic         err;
    int           acc;
  } beat_t;

  beat_t mq[$];
  int    cyc;
  int    cnt_wm;
  int    cnt_sm;
  int    total;
  int    bad;

  addsel_pipe #(.WIDTH(W), .NPAIR(NP), .SAT(0), .CNTW(CWA)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_w),
    .sel(sel), .din(din), .out_valid(out_valid_w), .out_ready(out_ready),
    .dout(dout_w), .dout_ovf(ovf_w), .sel_err(err_w), .ovf_cnt(cnt_w),
    .clr_cnt(clr_cnt)
  );

  addsel_pipe #(.WIDTH(W), .NPAIR(NP), .SAT(1), .CNTW(CWB)) dut_sat (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .sel(sel), .din(din), .out_valid(out_valid_s), .out_ready(out_ready),
    .dout(dout_s), .dout_ovf(ovf_s), .sel_err(err_s), .ovf_cnt(cnt_s),
    .clr_cnt(clr_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // The oldest beat is visible one edge after the edge that accepted it.
  // Anything ahead of it has already gone.
  function automatic logic model_valid();
    return (mq.size() > 0) && ((cyc - mq[0].acc) >= 1);
  endfunction

  // Two beats can be held. A full pipe still takes a beat when the oldest
  // one leaves this cycle.
  function automatic logic model_in_ready();
    return (mq.size() < 2) || out_ready;
  endfunction

  task automatic applyStimulus(input logic iv, input logic [SELW-1:0] s,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic orr, input logic clr);
    logic [2*NP*W-1:0] d;
    int p;
    for (int i = 0; i < 2*NP; i++) d[i*W +: W] = W'($urandom);
    p = (int'(s) < NP) ? int'(s) : 0;
    d[(2*p)*W +: W]   = a;
    d[(2*p+1)*W +: W] = b;
    in_valid  = iv;
    sel       = s;
    din       = d;
    out_ready = orr;
    clr_cnt   = clr;
  endtask

  task automatic checkAll();
    checkOutput("in_ready", in_ready_w, model_in_ready());
    checkOutput("in_ready_sat", in_ready_s, model_in_ready());
    checkOutput("out_valid", out_valid_w, model_valid());
    checkOutput("out_valid_sat", out_valid_s, model_valid());
    if (model_valid()) begin
      checkOutput("dout", dout_w, mq[0].wrap_sum);
      checkOutput("dout_sat", dout_s, mq[0].sat_sum);
      checkOutput("dout_ovf", ovf_w, mq[0].ovf);
      checkOutput("dout_ovf_sat", ovf_s, mq[0].ovf);
      checkOutput("sel_err", err_w, mq[0].err);
      checkOutput("sel_err_sat", err_s, mq[0].err);
    end
    checkOutput("ovf_cnt", cnt_w, cnt_wm);
    checkOutput("ovf_cnt_sat", cnt_s, cnt_sm);
  endtask

  task automatic modelEdge();
    logic  in_fire, out_fire;
    int    p, av, bv, s;
    beat_t nb;
    in_fire  = in_valid && model_in_ready();
    out_fire = model_valid() && out_ready;
    if (clr_cnt) begin
      cnt_wm = 0;
      cnt_sm = 0;
    end else if (out_fire && mq[0].ovf) begin
      if (cnt_wm < (1 << CWA) - 1) cnt_wm++;
      if (cnt_sm < (1 << CWB) - 1) cnt_sm++;
    end
    if (out_fire) void'(mq.pop_front());
    cyc++;
    if (in_fire) begin
      p  = (int'(sel) < NP) ? int'(sel) : 0;
      av = int'(din[(2*p)*W +: W]);
      bv = int'(din[(2*p+1)*W +: W]);
      s  = av + bv;
      nb.ovf      = (s > 255);
      nb.wrap_sum = W'(s % 256);
      nb.sat_sum  = W'((s > 255) ? 255 : s);
      nb.err      = (int'(sel) >= NP);
      nb.acc      = cyc;
      mq.push_back(nb);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    checkAll();
    @(posedge Clk);
    modelEdge();
    #1;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    cyc    = 0;
    cnt_wm = 0;
    cnt_sm = 0;
    Reset  = 1'b0;
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (3) @(posedge Clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_out_valid", out_valid_w, 1'b0);
    checkOutput("rst_dout", dout_w, 8'h00);
    checkOutput("rst_ovf", ovf_w, 1'b0);
    checkOutput("rst_err", err_w, 1'b0);
    checkOutput("rst_cnt", cnt_w, 0);
    checkOutput("rst_out_valid_sat", out_valid_s, 1'b0);
    checkOutput("rst_cnt_sat", cnt_s, 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checkOutput("rel_in_ready", in_ready_w, 1'b1);

    $display("[TB] latency and continuous sums");
    applyStimulus(1'b1, 2'd0, 8'h10, 8'h20, 1'b1, 1'b0);
    tick();
    checkOutput("lat_1_valid", out_valid_w, 1'b0);
    applyStimulus(1'b1, 2'd0, 8'h10, 8'h20, 1'b1, 1'b0);
    tick();
    checkOutput("lat_2_valid", out_valid_w, 1'b1);
    checkOutput("lat_2_dout", dout_w, 8'h30);
    repeat (4) begin
      applyStimulus(1'b1, 2'd0, 8'h10, 8'h20, 1'b1, 1'b0);
      tick();
    end
    checkOutput("cont_dout", dout_w, 8'h30);
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("drain_empty", out_valid_w, 1'b0);

    $display("[TB] overflow wrap and saturate");
    applyStimulus(1'b1, 2'd1, 8'hF0, 8'h20, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("ovf_dout_wrap", dout_w, 8'h10);
    checkOutput("ovf_flag_wrap", ovf_w, 1'b1);
    checkOutput("ovf_dout_sat", dout_s, 8'hFF);
    checkOutput("ovf_flag_sat", ovf_s, 1'b1);
    tick();
    checkOutput("ovf_cnt_1", cnt_w, 1);
    checkOutput("ovf_cnt_1_sat", cnt_s, 1);

    $display("[TB] select range");
    applyStimulus(1'b1, 2'd3, 8'h05, 8'h07, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd2, 8'h01, 8'h02, 1'b1, 1'b0);
    tick();
    checkOutput("sel3_err", err_w, 1'b1);
    checkOutput("sel3_dout", dout_w, 8'h0C);
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("sel2_err", err_w, 1'b0);
    checkOutput("sel2_dout", dout_w, 8'h03);
    tick();

    $display("[TB] overflow tally saturation");
    repeat (4) begin
      applyStimulus(1'b1, 2'd1, 8'hF0, 8'h20, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("cnt_stick", cnt_w, 3);
    checkOutput("cnt_sat_5", cnt_s, 5);

    $display("[TB] clear beats increment");
    applyStimulus(1'b1, 2'd0, 8'h80, 8'h80, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("clr_pre_ovf", ovf_w, 1'b1);
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("clr_cnt", cnt_w, 0);
    checkOutput("clr_cnt_sat", cnt_s, 0);
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    tick();

    $display("[TB] backpressure stall");
    repeat (5) begin
      applyStimulus(1'b1, SELW'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'b0, 1'b0);
      tick();
    end
    checkOutput("stall_in_ready", in_ready_w, 1'b0);
    checkOutput("stall_valid", out_valid_w, 1'b1);
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("stall_drained", out_valid_w, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, SELW'($urandom_range(0, 3)),
                    W'($urandom), W'($urandom),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
      tick();
    end

    $display("[TB] reset with both stages full");
    applyStimulus(1'b1, 2'd0, 8'h01, 8'h02, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'd0, 8'h03, 8'h04, 1'b0, 1'b0);
    tick();
    checkOutput("full_valid", out_valid_w, 1'b1);
    checkOutput("full_in_ready", in_ready_w, 1'b0);
    Reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", out_valid_w, 1'b0);
    checkOutput("mid_rst_dout", dout_w, 8'h00);
    checkOutput("mid_rst_valid_sat", out_valid_s, 1'b0);
    checkOutput("mid_rst_dout_sat", dout_s, 8'h00);
    checkOutput("mid_rst_cnt", cnt_w, 0);
    mq.delete();
    cnt_wm = 0;
    cnt_sm = 0;
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checkOutput("post_rst_valid", out_valid_w, 1'b0);
    checkOutput("post_rst_in_ready", in_ready_w, 1'b1);
    applyStimulus(1'b1, 2'd2, 8'h11, 8'h22, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
